// File: rtl/elm_weight_loader.sv
// elm_weight_loader: streams AXI-S weight words into per-neuron weight RAMs, neuron-major.
// Optional tlast framing check enabled by defining WEIGHT_LOADER_TLAST_CHECK_EN.
module elm_weight_loader #(
  parameter int numNeurons   = 42,
  parameter int numWeight    = 784,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int neuronWidth  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [dataWidth-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   wen,
  output logic [addressWidth:0]  waddr,
  output logic [dataWidth-1:0]   wdata,
  output logic [neuronWidth-1:0] wsel,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERR = 2'd3;
  localparam logic [addressWidth:0]  LAST_A = (addressWidth+1)'(numWeight - 1);
  localparam logic [neuronWidth-1:0] LAST_N = neuronWidth'(numNeurons - 1);
  logic [1:0]               state_q, state_d;
  logic [addressWidth:0]    addr_q, addr_d, waddr_q;
  logic [neuronWidth-1:0]   nrn_q, nrn_d, wsel_q;
  logic [dataWidth-1:0]     wdata_q;
  logic                     tready_q, tready_d, wen_q, done_q, err_q, err_d;
  logic                     accept, last_word, addr_wrap, frame_err;
  assign accept    = tready_q & s_axis_tvalid;
  assign addr_wrap = addr_q == LAST_A;
  assign last_word = addr_wrap && nrn_q == LAST_N;
`ifdef WEIGHT_LOADER_TLAST_CHECK_EN
  assign frame_err = accept & (s_axis_tlast ^ last_word);
`else
  // tlast carries no meaning when the load is framed purely by word count
  assign frame_err = s_axis_tlast & 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    nrn_d   = nrn_q;
    err_d   = err_q;
    if (start && (state_q == IDLE || state_q == ERR)) begin
      state_d = LOAD;
      addr_d  = '0;
      nrn_d   = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      addr_d  = addr_wrap ? '0 : addr_q + 1'b1;
      nrn_d   = addr_wrap ? nrn_q + 1'b1 : nrn_q;
      state_d = frame_err ? ERR : last_word ? DONE : LOAD;
      err_d   = err_q | frame_err;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    tready_d = state_d == LOAD;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      nrn_q    <= '0;
      tready_q <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wsel_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      nrn_q    <= nrn_d;
      tready_q <= tready_d;
      wen_q    <= accept;
      done_q   <= state_q == DONE;
      err_q    <= err_d;
      if (accept) begin
        waddr_q <= addr_q;
        wdata_q <= s_axis_tdata;
        wsel_q  <= nrn_q;
      end
    end
  end
  assign s_axis_tready = tready_q;
  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wsel  = wsel_q;
  assign busy  = state_q == LOAD;
  assign done  = done_q;
  assign err   = err_q;
endmodule

// File: tb/tb_elm_weight_loader.sv
// tb_elm_weight_loader: directed vectors for a 2x4 loader plus a full-size default load.
module tb_elm_weight_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        start = 1'b0, tvalid = 1'b0, tlast = 1'b0, tready;
  logic [15:0] tdata = '0, wdata;
  logic        wen, busy, done, err;
  logic [10:0] waddr;
  logic [5:0]  wsel;
  elm_weight_loader #(.numNeurons(2), .numWeight(4), .addressWidth(10), .dataWidth(16), .neuronWidth(6)) dut (
    .clk(clk), .rst(rst), .start(start), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wsel(wsel), .busy(busy), .done(done), .err(err));
  logic        b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0, b_tready, b_wen, b_busy, b_done, b_err;
  logic [15:0] b_data = '0, b_wdata;
  logic [10:0] b_waddr;
  logic [5:0]  b_wsel;
  elm_weight_loader big (
    .clk(clk), .rst(rst), .start(b_start), .s_axis_tdata(b_data), .s_axis_tvalid(b_valid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_last), .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
    .wsel(b_wsel), .busy(b_busy), .done(b_done), .err(b_err));
  int total = 0, bad = 0, wr_idx = 0, dn_cnt = 0;
  typedef struct {
    logic        start, valid, last;
    logic [15:0] data;
    logic [37:0] exp;
  } vec_t;
  vec_t vt[11];
  function automatic logic [37:0] pk(logic w, int a, int s, int d, logic tr, logic bz, logic dn, logic er);
    return {w, 11'(a), 6'(s), 16'(d), tr, bz, dn, er};
  endfunction
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (wen) begin
      chk("write", {wsel, waddr, wdata}, {6'(wr_idx / 4), 11'(wr_idx % 4), 16'(wr_idx + 1)});
      wr_idx++;
    end
    if (done) dn_cnt++;
  endtask
  task automatic load(input bit gap, input int restart_at, input int stop_after, input int tlast_at);
    int w = 0, cyc = 0;
    bit tog = 1'b0, acc;
    wr_idx = 0;
    dn_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (w < 8 && w != stop_after && cyc < 100 && !err) begin
      tvalid = !(gap && tog);
      tog = !tog;
      tdata = 16'(w + 1);
      tlast = (w == tlast_at);
      start = (w == restart_at);
      acc = tvalid && tready;
      tick();
      if (acc) w++;
      cyc++;
      {tvalid, tlast, start} = '0;
    end
    if (cyc >= 100) chk("load_timeout", 64'(cyc), 64'(0));
  endtask
  task automatic settle(string nm, int exp_wr, int exp_dn, logic exp_err);
    repeat (3) tick();
    chk({nm, "_writes"}, 64'(wr_idx), 64'(exp_wr));
    chk({nm, "_dones"}, 64'(dn_cnt), 64'(exp_dn));
    chk({nm, "_err_tready_busy"}, {err, tready, busy}, {exp_err, 2'b00});
  endtask
  initial begin
    int k, n, cyc, last_sel, last_addr;
    bit order_bad, seen_done, acc;
    vt[0] = '{1'b1, 1'b0, 1'b0, 16'd0, pk(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0)};
    for (int i = 1; i <= 8; i++)
      vt[i] = '{1'b0, 1'b1, i == 8, 16'(i), pk(1'b1, (i - 1) % 4, (i - 1) / 4, i, i < 8, i < 8, 1'b0, 1'b0)};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 16'd0, pk(1'b0, 3, 1, 8, 1'b0, 1'b0, 1'b1, 1'b0)};
    vt[10] = '{1'b0, 1'b0, 1'b0, 16'd0, pk(1'b0, 3, 1, 8, 1'b0, 1'b0, 1'b0, 1'b0)};
    #2;
    chk("reset_outputs", {wen, waddr, wsel, wdata, tready, busy, done, err}, 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      {start, tvalid, tlast, tdata} = {vt[i].start, vt[i].valid, vt[i].last, vt[i].data};
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {wen, waddr, wsel, wdata, tready, busy, done, err}, vt[i].exp);
    end
    {start, tvalid, tlast} = '0;
    load(1'b1, -1, -1, 7);
    settle("gaps", 8, 1, 1'b0);
    load(1'b0, 3, -1, 7);
    settle("restart_ignored", 8, 1, 1'b0);
    load(1'b0, -1, 5, 7);
    rst = 1'b1;
    #1;
    chk("rst_abort", {wen, tready, busy, done, err}, 5'b0);
    @(posedge clk);
    #1;
    chk("rst_hold", {wen, tready, busy}, 3'b0);
    rst = 1'b0;
    load(1'b0, -1, -1, 7);
    settle("reload", 8, 1, 1'b0);
    load(1'b0, -1, -1, 2);
`ifdef WEIGHT_LOADER_TLAST_CHECK_EN
    settle("early_tlast", 3, 0, 1'b1);
`else
    settle("early_tlast", 8, 1, 1'b0);
`endif
    load(1'b0, -1, -1, 7);
    settle("after_err", 8, 1, 1'b0);
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    {k, n, cyc, last_sel, last_addr, order_bad, seen_done} = '0;
    while (cyc < 40000 && !seen_done) begin
      b_valid = k < 32928;
      b_data = 16'(k + 1);
      b_last = k == 32927;
      acc = b_valid && b_tready;
      @(posedge clk);
      #1;
      if (acc) k++;
      if (b_wen) begin
        if (b_wsel != 6'(n / 784) || b_waddr != 11'(n % 784) || b_wdata != 16'(n + 1)) order_bad = 1'b1;
        last_sel = int'(b_wsel);
        last_addr = int'(b_waddr);
        n++;
      end
      if (b_done) seen_done = 1'b1;
      cyc++;
    end
    b_valid = 1'b0;
    chk("big_done", 64'(seen_done), 64'(1));
    chk("big_writes", 64'(n), 64'(32928));
    chk("big_order", 64'(order_bad), 64'(0));
    chk("big_last", {32'(last_sel), 32'(last_addr)}, {32'd41, 32'd783});
    chk("big_idle", {b_tready, b_busy, b_err}, 3'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
